muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl_pkg.sv | 25 ++
 rtl/muldiv_ctrl_if.sv | 34 +++
 rtl/muldiv_iter.sv | 57 +++++
 rtl/muldiv_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide sequencer.
// The optional MULDIV_FAST_MULT_EN build swaps the iterative multiply for a registered one.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is the right unsigned value.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO unit bundle; master is the execute stage, slave is muldiv_ctrl.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  // go is a one-cycle issue strobe taken on the clock edge unless mthi/mtlo/abort is also high;
  // there is no ready: a go while busy simply replaces the operation in flight. busy stays high
  // until the result lands, done pulses for the cycle the new HI/LO become visible, and hold
  // asks an MFHI/MFLO (mf_req) to wait while busy.
  logic        go;
  logic [1:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        mthi;
  logic        mtlo;
  logic        mf_req;
  logic        abort;
  logic        busy;
  logic        hold;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  md_state_t   state;

  modport master (
    output go, op, op1, op2, mthi, mtlo, mf_req, abort,
    input  busy, hold, hi, lo, done, state
  );

  modport slave (
    input  go, op, op1, op2, mthi, mtlo, mf_req, abort,
    output busy, hold, hi, lo, done, state
  );

endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-step datapath: shift-add multiply on {upper, lower} or restoring divide
// on {remainder, quotient}. Operates on magnitudes; sign fixup lives in the controller.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         div_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] upper,
  output logic [W-1:0] lower
);

  logic [W-1:0] upper_q, lower_q, opnd_q;
  logic [W:0]   sum;
  logic [W:0]   rem_sh;
  logic [W-1:0] diff;
  logic         fits;

  always_comb begin
    sum    = {1'b0, upper_q} + {1'b0, opnd_q};
    rem_sh = {upper_q, lower_q[W-1]};
    fits   = (rem_sh >= {1'b0, opnd_q});
    // Only the low W bits of the trial difference survive a successful subtract.
    diff   = rem_sh[W-1:0] - opnd_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      upper_q <= '0;
      lower_q <= '0;
      opnd_q  <= '0;
    end else if (load) begin
      upper_q <= '0;
      lower_q <= div_mode ? a : b;
      opnd_q  <= div_mode ? b : a;
    end else if (step) begin
      if (!div_mode) begin
        if (lower_q[0]) {upper_q, lower_q} <= {sum, lower_q[W-1:1]};
        else            {upper_q, lower_q} <= {1'b0, upper_q, lower_q[W-1:1]};
      end else if (fits) begin
        upper_q <= diff;
        lower_q <= {lower_q[W-2:0], 1'b1};
      end else begin
        upper_q <= rem_sh[W-1:0];
        lower_q <= {lower_q[W-2:0], 1'b0};
      end
    end
  end

  assign upper = upper_q;
  assign lower = lower_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, sign latches, fixup and HI/LO.
// Define MULDIV_FAST_MULT_EN for a two-cycle registered multiplier on MULT/MULTU.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input logic          clock,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt, go_cnt;
  logic             is_div, neg_q, neg_r, div0;
  logic [31:0]      op1_q, hi_q, lo_q;
  logic             busy_q, done_q;
  logic             cancel, take_go, is_div_in, is_sgn_in;
  logic [31:0]      mag1, mag2, it_upper, it_lower, fix_hi, fix_lo;
  logic [63:0]      prod;

  always_comb begin
    cancel    = bus.mthi | bus.mtlo | bus.abort;
    take_go   = bus.go & ~cancel;
    is_div_in = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
    is_sgn_in = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    mag1      = md_mag(bus.op1, is_sgn_in);
    mag2      = md_mag(bus.op2, is_sgn_in);
    go_cnt    = CNT_W'(ITER - 1);
`ifdef MULDIV_FAST_MULT_EN
    // Fast multiply spends one RUN cycle and one FIX cycle.
    if (!is_div_in) go_cnt = '0;
`endif
  end

  muldiv_iter #(.W(32)) u_iter (
    .clock    (clock),
    .reset    (reset),
    .load     (take_go),
    .step     (state == MD_RUN),
    .div_mode (take_go ? is_div_in : is_div),
    .a        (mag1),
    .b        (mag2),
    .upper    (it_upper),
    .lower    (it_lower)
  );

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_a, fast_b, fast_prod_q;

  always_comb begin
    fast_a = {{32{is_sgn_in & bus.op1[31]}}, bus.op1};
    fast_b = {{32{is_sgn_in & bus.op2[31]}}, bus.op2};
  end

  // Low 64 bits of the extended product are exact for both signed and unsigned operands.
  always_ff @(posedge clock) begin
    if (reset)        fast_prod_q <= '0;
    else if (take_go) fast_prod_q <= fast_a * fast_b;
  end

  assign prod = fast_prod_q;
`else
  assign prod = neg_q ? -{it_upper, it_lower} : {it_upper, it_lower};
`endif

  always_comb begin
    {fix_hi, fix_lo} = prod;
    if (is_div) begin
      if (div0) begin
        fix_hi = op1_q;
        fix_lo = MD_DIV0_LO;
      end else begin
        fix_hi = neg_r ? -it_upper : it_upper;
        fix_lo = neg_q ? -it_lower : it_lower;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      op1_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.mthi || bus.mtlo) begin
        if (bus.mthi) hi_q <= bus.op1;
        if (bus.mtlo) lo_q <= bus.op1;
        state  <= MD_IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else if (bus.abort) begin
        state  <= MD_IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else if (bus.go) begin
        state  <= MD_RUN;
        cnt    <= go_cnt;
        busy_q <= 1'b1;
        is_div <= is_div_in;
        neg_q  <= is_sgn_in & (bus.op1[31] ^ bus.op2[31]);
        neg_r  <= is_sgn_in & bus.op1[31];
        div0   <= is_div_in && (bus.op2 == 32'd0);
        op1_q  <= bus.op1;
      end else begin
        case (state)
          MD_RUN: begin
            if (cnt == '0) state <= MD_FIX;
            else           cnt   <= cnt - 1'b1;
          end
          MD_FIX: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= MD_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hold  = bus.mf_req & busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule
